// File: rtl/lcd_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_driver_if                                                 |
// | Purpose  : Bundles the 32-character text word feeding the LCD driver     |
// |            together with the HD44780 pins and status flags it produces.  |
// | Signals  : lcd_text   [255:0] 32 characters, byte i at [255-8i -: 8]     |
// |            lcd_data   [7:0]   LCD data bus                               |
// |            lcd_rs             0 = command, 1 = character                 |
// |            lcd_rw             write only, always 0                       |
// |            lcd_en             enable strobe                              |
// |            lcd_on, lcd_blon   panel power / backlight, always 1          |
// |            ready              init sequence complete                     |
// |            frame_done         one-cycle end-of-frame pulse               |
// | Modports : master - the driver (consumes text, drives the panel pins)    |
// |            slave  - text source / panel side                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface lcd_driver_if;
  logic [255:0] lcd_text;
  logic [7:0]   lcd_data;
  logic         lcd_rs;
  logic         lcd_rw;
  logic         lcd_en;
  logic         lcd_on;
  logic         lcd_blon;
  logic         ready;
  logic         frame_done;

  modport master (
    input  lcd_text,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, ready, frame_done
  );

  modport slave (
    output lcd_text,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, ready, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_driver                                                    |
// | Purpose  : Runs the HD44780 power-up/init sequence, then repaints a 16x2 |
// |            character LCD forever from a per-frame snapshot of lcd_text,  |
// |            left-justifying the text (leading NULs stripped, NUL -> ' ').|
// | Ports    : clock  - system clock                                         |
// |            reset  - synchronous, active-high                             |
// |            bus    - lcd_driver_if.master (text in, LCD pins/status out)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lcd_driver #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES   = 2,
  parameter int EN_CYCLES      = 25,
  parameter int EXEC_CYCLES    = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic         clock,
  input  logic         reset,
  lcd_driver_if.master bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYCLES = imax(imax(imax(POWERUP_CYCLES, SETUP_CYCLES),
                                        imax(EN_CYCLES, EXEC_CYCLES)), CLEAR_CYCLES);
  // The counter only ever holds (length - 1), so clog2(max) bits suffice.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;  // display on, no cursor
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_ENTRY      = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE1      = 8'h80;
  localparam logic [7:0] CMD_LINE2      = 8'hC0;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_t;

  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;          // init command index or character column
  logic [255:0]     frame_buf;
  logic [7:0]       data_drv;
  logic             rs_drv;
  logic             en_drv;
  logic             ready_flag;
  logic             frame_pulse;

  logic [5:0]       lead;         // leading NUL bytes in the snapshot (0..32)
  logic [3:0]       idx_next;
  logic [CNT_W-1:0] wait_last;
  logic             wait_is_one;
  logic             wait_done;
  logic             last_wait_next;
  logic             load_snapshot;

  // Lowest-numbered non-NUL byte wins, so scan from the top down.
  always_comb begin
    lead = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (frame_buf[8*(31-i) +: 8] != 8'h00) lead = 6'(i);
    end
  end

  // Character shown at screen position pos after left-justification.
  // Byte i lives at bit offset 8*(31-i), i.e. {~i, 3'b000} for 5-bit i.
  function automatic logic [7:0] char_at(input logic [4:0] pos);
    logic [5:0] src;
    logic [7:0] ch;
    src = {1'b0, pos} + lead;
    ch  = frame_buf[{~src[4:0], 3'b000} +: 8];
    if (src[5] || (ch == 8'h00)) return CHAR_SPACE;
    return ch;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISPLAY_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  assign idx_next  = idx + 4'd1;
  // The clear command (third init write) needs the long execution wait.
  assign wait_last   = ((state == ST_INIT) && (idx == 4'd2)) ? CLEAR_LAST : EXEC_LAST;
  assign wait_is_one = (wait_last == '0);
  assign wait_done   = (phase == PH_WAIT) && (cnt == wait_last);

  // True when the next cycle is the final WAIT cycle of the current write;
  // lets frame_done be registered yet still coincide with that cycle.
  assign last_wait_next = ((phase == PH_PULSE) && (cnt == EN_LAST) && wait_is_one) ||
                          ((phase == PH_WAIT) && !wait_is_one && (cnt == wait_last - 1'b1));

  // Snapshot on every edge that enters ADDR1 (end of init or end of line 2).
  assign load_snapshot = !reset && (state != ST_POWERUP) && wait_done &&
                         (((state == ST_INIT)  && (idx == 4'd3)) ||
                          ((state == ST_LINE2) && (idx == 4'd15)));

  always_ff @(posedge clock) begin
    if (load_snapshot) frame_buf <= bus.lcd_text;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_POWERUP;
      phase       <= PH_SETUP;
      cnt         <= '0;
      idx         <= '0;
      data_drv    <= 8'h00;
      rs_drv      <= 1'b0;
      en_drv      <= 1'b0;
      ready_flag  <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= (state == ST_LINE2) && (idx == 4'd15) && last_wait_next;
      case (state)
        ST_POWERUP: begin
          if (cnt == PWR_LAST) begin
            state    <= ST_INIT;
            phase    <= PH_SETUP;
            cnt      <= '0;
            idx      <= 4'd0;
            data_drv <= CMD_FUNC_SET;
            rs_drv   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          case (phase)
            PH_SETUP: begin
              if (cnt == SETUP_LAST) begin
                phase  <= PH_PULSE;
                cnt    <= '0;
                en_drv <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_PULSE: begin
              if (cnt == EN_LAST) begin
                phase  <= PH_WAIT;
                cnt    <= '0;
                en_drv <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_WAIT: begin
              if (wait_done) begin
                // Next write's SETUP starts immediately; data/rs are
                // loaded here so they are stable through the whole write.
                phase <= PH_SETUP;
                cnt   <= '0;
                case (state)
                  ST_INIT: begin
                    if (idx == 4'd3) begin
                      state      <= ST_ADDR1;
                      data_drv   <= CMD_LINE1;
                      rs_drv     <= 1'b0;
                      ready_flag <= 1'b1;
                    end else begin
                      idx      <= idx_next;
                      data_drv <= init_cmd(idx_next[1:0]);
                      rs_drv   <= 1'b0;
                    end
                  end
                  ST_ADDR1: begin
                    state    <= ST_LINE1;
                    idx      <= 4'd0;
                    data_drv <= char_at(5'd0);
                    rs_drv   <= 1'b1;
                  end
                  ST_LINE1: begin
                    if (idx == 4'd15) begin
                      state    <= ST_ADDR2;
                      data_drv <= CMD_LINE2;
                      rs_drv   <= 1'b0;
                    end else begin
                      idx      <= idx_next;
                      data_drv <= char_at({1'b0, idx_next});
                      rs_drv   <= 1'b1;
                    end
                  end
                  ST_ADDR2: begin
                    state    <= ST_LINE2;
                    idx      <= 4'd0;
                    data_drv <= char_at(5'd16);
                    rs_drv   <= 1'b1;
                  end
                  ST_LINE2: begin
                    if (idx == 4'd15) begin
                      state    <= ST_ADDR1;
                      data_drv <= CMD_LINE1;
                      rs_drv   <= 1'b0;
                    end else begin
                      idx      <= idx_next;
                      data_drv <= char_at({1'b1, idx_next});
                      rs_drv   <= 1'b1;
                    end
                  end
                  default: begin
                    state <= ST_POWERUP;
                  end
                endcase
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              phase <= PH_SETUP;
              cnt   <= '0;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.lcd_data   = data_drv;
  assign bus.lcd_rs     = rs_drv;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = en_drv;
  assign bus.lcd_on     = 1'b1;
  assign bus.lcd_blon   = 1'b1;
  assign bus.ready      = ready_flag;
  assign bus.frame_done = frame_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd_driver                                                 |
// | Purpose  : Self-checking bench for lcd_driver with short timing          |
// |            parameters (7-cycle writes, 11-cycle clear, 238-cycle frame). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lcd_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_driver_if bus ();

  lcd_driver #(
    .POWERUP_CYCLES(20),
    .SETUP_CYCLES  (1),
    .EN_CYCLES     (2),
    .EXEC_CYCLES   (4),
    .CLEAR_CYCLES  (8)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [255:0] text;
    logic [255:0] disp;
    string        name;
  } vec_t;

  vec_t tbl [5];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   last_rise = 0;
  int   prev_fd   = 0;
  logic prev_en   = 1'b0;
  logic rose      = 1'b0;

  task automatic summary_and_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All waiting goes through here so EN edge tracking never misses a cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    rose    = (bus.lcd_en === 1'b1) && (prev_en !== 1'b1);
    prev_en = bus.lcd_en;
  endtask

  task automatic next_write(output logic [8:0] w, output int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rose && n < 400);
    if (!rose) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: no EN rise within %0d cycles (cycle %0d)", n, cyc);
      summary_and_stop();
    end
    w = {bus.lcd_rs, bus.lcd_data};
    c = cyc;
  endtask

  task automatic expect_write(input logic [8:0] exp, input int gap, input string name);
    logic [8:0] w;
    int         c;
    next_write(w, c);
    chk(name, 32'(w), 32'(exp));
    if (gap > 0) chk({name, "_gap"}, 32'(c - last_rise), 32'(gap));
    last_rise = c;
  endtask

  // Waits for frame_done; optionally presents new text in that same cycle
  // so the following ADDR1 edge snapshots it.
  task automatic wait_fd(input logic [255:0] new_text, input logic change);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_done !== 1'b1 && n < 400);
    if (bus.frame_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_done_timeout: no pulse within %0d cycles (cycle %0d)", n, cyc);
      summary_and_stop();
    end
    if (prev_fd > 0) chk("frame_period", 32'(cyc - prev_fd), 32'd238);
    prev_fd = cyc;
    if (change) bus.lcd_text = new_text;
    tick();
    chk("frame_done_width", 32'(bus.frame_done), 32'd0);
  endtask

  task automatic check_frame(input logic [255:0] disp, input int sw_at,
                             input logic [255:0] sw_text, input string name);
    expect_write({1'b0, 8'h80}, 7, {name, "_addr1"});
    chk({name, "_ready"}, 32'(bus.ready), 32'd1);
    for (int p = 0; p < 32; p++) begin
      if (p == 16) expect_write({1'b0, 8'hC0}, 7, {name, "_addr2"});
      expect_write({1'b1, disp[8*(31-p) +: 8]}, 7, $sformatf("%s_pos%0d", name, p));
      if (p == sw_at) bus.lcd_text = sw_text;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [8:0]   w;
    int           c;
    int           rel;
    logic [255:0] real_text, real_disp, comp_text, comp_disp;

    tbl[0] = '{"ABCDEFGHIJKLMNOPabcdefghijklmnop",
               "ABCDEFGHIJKLMNOPabcdefghijklmnop", "full"};
    tbl[1] = '{{224'h0, "Done"}, {"Done", {28{8'h20}}}, "short"};
    tbl[2] = '{256'h0, {32{8'h20}}, "empty"};
    tbl[3] = '{{16'h0000, "Hi", 8'h00, 8'hFF, {26{8'h41}}},
               {"Hi", 8'h20, 8'hFF, {26{8'h41}}, 16'h2020}, "inner_nul"};
    tbl[4] = '{{8'h00, "Z", {30{8'h7E}}}, {"Z", {30{8'h7E}}, 8'h20}, "one_nul"};

    real_text = {152'h0, "Enter c_real."};
    real_disp = {"Enter c_real.", {19{8'h20}}};
    comp_text = {152'h0, "Enter c_comp."};
    comp_disp = {"Enter c_comp.", {19{8'h20}}};

    // Reset state
    rst          = 1'b1;
    bus.lcd_text = tbl[0].text;
    repeat (3) tick();
    chk("rst_en",         32'(bus.lcd_en),     32'd0);
    chk("rst_rs",         32'(bus.lcd_rs),     32'd0);
    chk("rst_data",       32'(bus.lcd_data),   32'd0);
    chk("rst_rw",         32'(bus.lcd_rw),     32'd0);
    chk("rst_on",         32'(bus.lcd_on),     32'd1);
    chk("rst_blon",       32'(bus.lcd_blon),   32'd1);
    chk("rst_ready",      32'(bus.ready),      32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

    // Power-up delay and init sequence
    rst = 1'b0;
    rel = cyc;
    next_write(w, c);
    chk("init_func_set", 32'(w), 32'h038);
    chk("powerup_delay", 32'(c - rel), 32'd21);
    last_rise = c;
    expect_write({1'b0, 8'h0C}, 7,  "init_display_on");
    expect_write({1'b0, 8'h01}, 7,  "init_clear");
    expect_write({1'b0, 8'h06}, 11, "init_entry");
    repeat (5) tick();
    chk("ready_before_addr1", 32'(bus.ready), 32'd0);
    tick();
    chk("ready_at_addr1", 32'(bus.ready), 32'd1);

    // Table-driven frames
    check_frame(tbl[0].disp, -1, 256'h0, tbl[0].name);
    for (int i = 1; i < 5; i++) begin
      wait_fd(tbl[i].text, 1'b1);
      check_frame(tbl[i].disp, -1, 256'h0, tbl[i].name);
    end

    // Text changes during LINE1: current frame keeps the old snapshot
    wait_fd(real_text, 1'b1);
    check_frame(real_disp, 4, comp_text, "mid_old");
    wait_fd(256'h0, 1'b0);
    check_frame(comp_disp, -1, 256'h0, "mid_new");

    // Reset during the EN pulse of the first line-2 character
    wait_fd(256'h0, 1'b0);
    repeat (18) next_write(w, c);
    next_write(w, c);
    chk("reset_target_char", 32'(w), 32'h120);
    rst = 1'b1;
    tick();
    chk("midrst_en",    32'(bus.lcd_en),     32'd0);
    chk("midrst_ready", 32'(bus.ready),      32'd0);
    chk("midrst_data",  32'(bus.lcd_data),   32'd0);
    chk("midrst_rs",    32'(bus.lcd_rs),     32'd0);
    chk("midrst_fd",    32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    rel = cyc;
    next_write(w, c);
    chk("rerun_func_set",    32'(w), 32'h038);
    chk("rerun_powerup_dly", 32'(c - rel), 32'd21);

    summary_and_stop();
  end

endmodule
`default_nettype wire
